// File: rtl/operand_fetch_if.sv
// Bundle between decode, the register bank, writeback and execute for operand_fetch.
interface operand_fetch_if #(
    parameter int unsigned DW = 64
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rn;
    logic [4:0]    in_rm;
    logic [4:0]    in_rd;
    logic          in_uses_rm;
    logic          in_writes_rd;
    logic [4:0]    addr_a;
    logic [4:0]    addr_b;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          wb_w;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [4:0]    out_rd;
    logic          out_writes_rd;

    // Operand stage side
    modport slave (
        input  in_valid, in_rn, in_rm, in_rd, in_uses_rm, in_writes_rd,
        input  data_a, data_b, wb_w, wb_addr, wb_data, flush, out_ready,
        output in_ready, addr_a, addr_b,
        output out_valid, out_a, out_b, out_rd, out_writes_rd
    );

    // Decode / bank / execute side
    modport master (
        output in_valid, in_rn, in_rm, in_rd, in_uses_rm, in_writes_rd,
        output data_a, data_b, wb_w, wb_addr, wb_data, flush, out_ready,
        input  in_ready, addr_a, addr_b,
        input  out_valid, out_a, out_b, out_rd, out_writes_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// ID/EX operand stage: register-bank read with writeback bypass, scoreboard
// stalls for in-flight writes, and the ID/EX pipeline register.
module operand_fetch #(
    parameter int unsigned DW = 64
) (
    input  logic            clk,
    input  logic            rst,
    operand_fetch_if.slave  bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned NREG  = 32;
    localparam logic [AW-1:0] ZERO_REG = AW'(31);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            out_valid_q;
    logic [DW-1:0]   out_a_q;
    logic [DW-1:0]   out_b_q;
    logic [AW-1:0]   out_rd_q;
    logic            out_writes_rd_q;

    logic          byp_a;
    logic          byp_b;
    logic          haz_a;
    logic          haz_b;
    logic          haz_d;
    logic          ready;
    logic          accept;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;

    assign bus.addr_a = bus.in_rn;
    assign bus.addr_b = bus.in_rm;

    // Hazard detection, bypass select and issue decision
    always_comb begin
        byp_a  = 1'b0;
        byp_b  = 1'b0;
        haz_a  = 1'b0;
        haz_b  = 1'b0;
        haz_d  = 1'b0;
        opnd_a = bus.data_a;
        opnd_b = bus.data_b;

        byp_a = bus.wb_w && (bus.wb_addr == bus.in_rn) && (bus.in_rn != ZERO_REG);
        byp_b = bus.wb_w && (bus.wb_addr == bus.in_rm) && (bus.in_rm != ZERO_REG);

        haz_a = (bus.in_rn != ZERO_REG) && busy[bus.in_rn] && !byp_a;
        haz_b = bus.in_uses_rm && (bus.in_rm != ZERO_REG) && busy[bus.in_rm] && !byp_b;
        haz_d = bus.in_writes_rd && (bus.in_rd != ZERO_REG) && busy[bus.in_rd]
                && !(bus.wb_w && (bus.wb_addr == bus.in_rd));

        ready  = !bus.flush && !haz_a && !haz_b && !haz_d
                 && (!out_valid_q || bus.out_ready);
        accept = bus.in_valid && ready;

        if (bus.in_rn == ZERO_REG) opnd_a = '0;
        else if (byp_a)            opnd_a = bus.wb_data;

        if (bus.in_rm == ZERO_REG) opnd_b = '0;
        else if (byp_b)            opnd_b = bus.wb_data;
    end

    assign bus.in_ready = ready;

    // Scoreboard update: clears first so that a same-cycle set wins
    always_comb begin
        busy_next = busy;
        if (bus.wb_w && (bus.wb_addr != ZERO_REG))
            busy_next[bus.wb_addr] = 1'b0;
        if (bus.flush && out_valid_q && out_writes_rd_q && (out_rd_q != ZERO_REG))
            busy_next[out_rd_q] = 1'b0;
        if (accept && bus.in_writes_rd && (bus.in_rd != ZERO_REG))
            busy_next[bus.in_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_a_q         <= '0;
            out_b_q         <= '0;
            out_rd_q        <= '0;
            out_writes_rd_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q     <= 1'b0;
        end else if (accept) begin
            out_valid_q     <= 1'b1;
            out_a_q         <= opnd_a;
            out_b_q         <= opnd_b;
            out_rd_q        <= bus.in_rd;
            out_writes_rd_q <= bus.in_writes_rd;
        end else if (bus.out_ready) begin
            out_valid_q     <= 1'b0;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_a         = out_a_q;
    assign bus.out_b         = out_b_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_writes_rd = out_writes_rd_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 32 x 64 register bank.
module tb_operand_fetch;
    localparam int unsigned DW = 64;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [DW-1:0] bank [32];

    operand_fetch_if #(.DW(DW)) bus ();

    operand_fetch #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.data_a = bank[bus.addr_a];
    assign bus.data_b = bank[bus.addr_b];

    always @(posedge clk) begin
        if (bus.wb_w) bank[bus.wb_addr] <= bus.wb_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_rn        = 5'd0;
        bus.in_rm        = 5'd0;
        bus.in_rd        = 5'd0;
        bus.in_uses_rm   = 1'b0;
        bus.in_writes_rd = 1'b0;
        bus.wb_w         = 1'b0;
        bus.wb_addr      = 5'd0;
        bus.wb_data      = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic uses_rm, input logic writes_rd);
        bus.in_valid     = 1'b1;
        bus.in_rn        = rn;
        bus.in_rm        = rm;
        bus.in_rd        = rd;
        bus.in_uses_rm   = uses_rm;
        bus.in_writes_rd = writes_rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #12;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.out_a !== 64'd0 || bus.out_b !== 64'd0) begin fails++; $display("FAIL reset_out_ab: got %h/%h expected 0/0", bus.out_a, bus.out_b); end
        tests++; if (bus.out_rd !== 5'd0 || bus.out_writes_rd !== 1'b0) begin fails++; $display("FAIL reset_out_rd: got %0d/%b expected 0/0", bus.out_rd, bus.out_writes_rd); end
        @(negedge clk);
        rst = 1'b0;
        step();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        idle();
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        #1;
        tests++; if (bus.addr_a !== 5'd1 || bus.addr_b !== 5'd2) begin fails++; $display("FAIL basic_addr: got %0d/%0d expected 1/2", bus.addr_a, bus.addr_b); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready0: got %b expected 1", bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'd5 || bus.out_b !== 64'd7) begin fails++; $display("FAIL basic_first: got v=%b a=%h b=%h expected v=1 a=5 b=7", bus.out_valid, bus.out_a, bus.out_b); end
        issue(5'd2, 5'd1, 5'd9, 1'b1, 1'b0);
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_b2b_ready: got %b expected 1", bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'd7 || bus.out_b !== 64'd5 || bus.out_rd !== 5'd9) begin fails++; $display("FAIL basic_second: got v=%b a=%h b=%h rd=%0d expected v=1 a=7 b=5 rd=9", bus.out_valid, bus.out_a, bus.out_b, bus.out_rd); end
        idle();
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_raw_bypass();
        idle();
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        step();
        issue(5'd3, 5'd2, 5'd0, 1'b1, 1'b0);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall: got %b expected 0", bus.in_ready); end
        step();
        tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL raw_stall2: got ready=%b v=%b expected 0/0", bus.in_ready, bus.out_valid); end
        bus.wb_w    = 1'b1;
        bus.wb_addr = 5'd3;
        bus.wb_data = 64'hABCD;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL raw_wb_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.wb_w = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'hABCD || bus.out_b !== 64'd7) begin fails++; $display("FAIL raw_bypass: got v=%b a=%h b=%h expected v=1 a=abcd b=7", bus.out_valid, bus.out_a, bus.out_b); end
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        idle();
        bank[31] = 64'h1234;
        issue(5'd31, 5'd31, 5'd31, 1'b1, 1'b1);
        bus.wb_w    = 1'b1;
        bus.wb_addr = 5'd31;
        bus.wb_data = 64'hFF;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL zero_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.wb_w = 1'b0;
        tests++; if (bus.out_a !== 64'd0 || bus.out_b !== 64'd0 || bus.out_rd !== 5'd31) begin fails++; $display("FAIL zero_operands: got a=%h b=%h rd=%0d expected 0/0/31", bus.out_a, bus.out_b, bus.out_rd); end
        issue(5'd31, 5'd0, 5'd31, 1'b0, 1'b1);
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL zero_not_busy: got %b expected 1", bus.in_ready); end
        step();
        idle();
        step();
    endtask

    task automatic test_backpressure();
        idle();
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        step();
        issue(5'd2, 5'd1, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_a !== 64'd5 || bus.out_b !== 64'd7 || bus.out_rd !== 5'd5) begin fails++; $display("FAIL hold_cycle%0d: got r=%b v=%b a=%h b=%h rd=%0d expected r=0 v=1 a=5 b=7 rd=5", i, bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_rd); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready: got %b expected 1", bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'd7 || bus.out_rd !== 5'd8) begin fails++; $display("FAIL hold_release: got v=%b a=%h rd=%0d expected v=1 a=7 rd=8", bus.out_valid, bus.out_a, bus.out_rd); end
        idle();
        step();
    endtask

    task automatic test_flush();
        idle();
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
        step();
        issue(5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
        step();
        bus.flush = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_busy_cleared: got %b expected 1", bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'h44) begin fails++; $display("FAIL flush_reissue: got v=%b a=%h expected v=1 a=44", bus.out_valid, bus.out_a); end
        idle();
        step();
    endtask

    task automatic test_waw();
        idle();
        issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        step();
        issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL waw_stall: got %b expected 0", bus.in_ready); end
        step();
        bus.wb_w    = 1'b1;
        bus.wb_addr = 5'd6;
        bus.wb_data = 64'h66;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL waw_wb_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.wb_w = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd6) begin fails++; $display("FAIL waw_issue: got v=%b rd=%0d expected v=1 rd=6", bus.out_valid, bus.out_rd); end
        issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL waw_set_wins: got %b expected 0", bus.in_ready); end
        step();
        bus.wb_w    = 1'b1;
        bus.wb_addr = 5'd6;
        bus.wb_data = 64'h6677;
        step();
        bus.wb_w = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'h6677) begin fails++; $display("FAIL waw_final_read: got v=%b a=%h expected v=1 a=6677", bus.out_valid, bus.out_a); end
        idle();
        step();
    endtask

    task automatic test_async_reset();
        idle();
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        step();
        idle();
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.out_a !== 64'd0 || bus.out_rd !== 5'd0) begin fails++; $display("FAIL async_reset: got v=%b a=%h rd=%0d expected 0/0/0", bus.out_valid, bus.out_a, bus.out_rd); end
        @(negedge clk);
        rst = 1'b0;
        issue(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL async_reset_busy: got %b expected 1", bus.in_ready); end
        step();
        idle();
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = 64'(i) * 64'h100;
        bank[1] = 64'd5;
        bank[2] = 64'd7;
        bank[4] = 64'h44;
        idle();
        test_reset();
        test_basic();
        test_raw_bypass();
        test_zero_reg();
        test_backpressure();
        test_flush();
        test_waw();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand stage for the 64-bit pipelined core. It drives the two read addresses of the 32 x 64 register bank and captures the returned operands into the ID/EX pipeline register. It bypasses a same-cycle writeback that the bank has not yet committed, and stalls issue through a one-bit-per-register scoreboard of in-flight writes. Register 31 is the zero register: it always reads 0, is never marked busy and never causes a stall.

## Interface
- DW, 64, operand/data width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid is also 1
- in_rn, in_rm, in_rd  in  5 each  source A, source B, destination
- in_uses_rm  in  1  source B is a register (0: immediate form)
- in_writes_rd  in  1  instruction writes in_rd
- AddrA, AddrB  out  5 each  register-bank read addresses (= in_rn, in_rm, combinational)
- DataA, DataB  in  DW each  register-bank read data (combinational)
- wb_w, wb_addr, wb_data  in  1/5/DW  writeback port, the same signals driving the bank's w/AddrC/DataC
- flush  in  1  squash the ID/EX entry and block issue this cycle
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  execute stage takes the entry
- out_a, out_b  out  DW each  captured operands
- out_rd  out  5, out_writes_rd  out  1  destination info

## Operation
- Reset (async): busy[31:0]=0, out_valid=0, out_a=out_b=0, out_rd=0, out_writes_rd=0.
- bypA = wb_w && wb_addr==in_rn && in_rn!=31; bypB is the same with in_rm.
- hazA = in_rn!=31 && busy[in_rn] && !bypA.
- hazB = in_uses_rm && in_rm!=31 && busy[in_rm] && !bypB.
- hazD (WAW) = in_writes_rd && in_rd!=31 && busy[in_rd] && !(wb_w && wb_addr==in_rd).
- in_ready = !flush && !hazA && !hazB && !hazD && (!out_valid || out_ready).
- On accept (in_valid && in_ready), at the clock edge:
  - out_a <= 0 if in_rn==31, else wb_data if bypA, else DataA.
  - out_b <= the same rule with in_rm/bypB/DataB. When in_uses_rm=0, out_b is captured per that rule anyway; execute ignores it.
  - out_rd, out_writes_rd are captured; out_valid <= 1.
  - If in_writes_rd && in_rd!=31, set busy[in_rd].
- No accept while out_ready=1: out_valid <= 0. No accept while out_ready=0: the entry holds unchanged.
- Scoreboard clear: wb_w && wb_addr!=31 clears busy[wb_addr]. A writeback to a non-busy register is legal and leaves busy unchanged.
- Set and clear of the same register in the same cycle: set wins.
- Flush: out_valid <= 0 regardless of out_ready. If out_valid && out_writes_rd && out_rd!=31, clear busy[out_rd]; a same-cycle writeback clear on another register still applies. Flush never touches instructions already downstream.

## Timing
- Accept-to-out_valid latency is 1 cycle. Throughput is 1 instruction/cycle when there are no hazards.
- in_ready is combinational from in_*, busy, wb_*, flush, out_valid and out_ready. It does not depend on in_valid.
- Bypass is combinational from the same-cycle wb_*. The value the bank commits on that edge is forwarded, so the new value is never missed.
- A stalled instruction re-evaluates every cycle. It issues in the cycle its last blocking register is written back, with that value bypassed.
- Reset asserted mid-stream discards the ID/EX entry and all busy bits immediately, without waiting for a clock edge.

## Test plan
- Reset, then issue rn=1, rm=2 with bank X1=5, X2=7 and out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7; in_ready stays 1 on back-to-back issue.
- Issue writes_rd rd=3, then next instr rn=3 -> in_ready=0 until wb_w=1, wb_addr=3, wb_data=0xABCD; in that cycle in_ready=1 and the following cycle out_a=0xABCD.
- rn=31, rm=31 while wb_w=1, wb_addr=31, wb_data=0xFF -> out_a=out_b=0, no stall; writes_rd with rd=31 leaves busy all 0.
- out_ready=0 with out_valid=1 -> in_ready=0 and out_* hold values for 3 cycles; out_ready=1 -> the next instruction is accepted the same cycle.
- Entry rd=4, writes_rd=1, valid; assert flush -> out_valid=0, busy[4]=0, in_ready=0 that cycle; next cycle an instr reading X4 issues without stall.
- WAW: rd=6 busy, new instr writes rd=6 -> stalls; wb to 6 with a same-cycle issue -> busy[6] remains 1 (set wins).
